// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD sequencer.
// The top FSM and the byte transfer engine both import this package.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        WR_ADDR,
        WR_CHAR
    } state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_PULSE,
        X_SETTLE
    } xfer_state_t;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY;
            default: return CLEAR;
        endcase
    endfunction

    // Wait counters are at least 16 bits and wide enough to reach max_cyc.
    function automatic int cnt_width(input int max_cyc);
        int w;
        w = $clog2(max_cyc + 1);
        return (w < 16) ? 16 : w;
    endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// One LCD byte transaction: SETUP (1 cycle), PULSE (lcd_en high), SETTLE.
// lcd_rs/lcd_data are latched at start and held until the next start.
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int EN_HIGH_CYC  = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data_byte,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       done,
    output logic       ready
);

    localparam int MAX_A = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
    localparam int MAX_CYC = (MAX_A > CLR_WAIT_CYC) ? MAX_A : CLR_WAIT_CYC;
    localparam int CNT_W = cnt_width(MAX_CYC);

    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

    xfer_state_t      st;
    logic [CNT_W-1:0] cnt;
    logic             long_q;
    logic             settle_last;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        settle_last = 1'b0;
        if (cnt == (long_q ? CLR_LAST : CMD_LAST))
            settle_last = 1'b1;
    end

    // done fires in the last SETTLE cycle so the caller advances on the same edge the engine frees up.
    assign done  = (st == X_SETTLE) && settle_last;
    assign ready = (st == X_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= X_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (st)
                X_IDLE: begin
                    if (start) begin
                        lcd_rs   <= rs;
                        lcd_data <= data_byte;
                        long_q   <= long_wait;
                        st       <= X_SETUP;
                    end
                end
                X_SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                    st     <= X_PULSE;
                end
                X_PULSE: begin
                    if (cnt == EN_LAST) begin
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                        st     <= X_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                X_SETTLE: begin
                    if (settle_last) begin
                        cnt <= '0;
                        st  <= X_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// HD44780-style sequencer: power-up wait, init commands, then on request
// rewrites three characters at the start of line 1.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT_CYC = 750000,
    parameter int EN_HIGH_CYC  = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_req,
    input  logic [7:0] digit1,
    input  logic [7:0] digit2,
    input  logic [7:0] digit3,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam int PWR_W = cnt_width(PWR_WAIT_CYC);
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_WAIT_CYC - 1);

    state_t           state;
    logic [PWR_W-1:0] pwr_cnt;
    logic [1:0]       idx;
    logic             issued;
    logic             pending;
    logic [7:0]       cap_d1, cap_d2, cap_d3;
    logic             x_start, x_rs, x_long;
    logic [7:0]       x_byte;
    logic             x_done, x_ready;
    logic [7:0]       char_sel;
    logic [7:0]       init_byte;

    assign lcd_rw = 1'b0;

    always_comb begin
        init_byte = init_cmd(idx);
        char_sel  = cap_d1;
        case (idx)
            2'd1:    char_sel = cap_d2;
            2'd2:    char_sel = cap_d3;
            default: char_sel = cap_d1;
        endcase
    end

    // issued marks a byte handed to the engine; start is only raised while the engine is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            pwr_cnt   <= '0;
            idx       <= 2'd0;
            issued    <= 1'b0;
            pending   <= 1'b0;
            cap_d1    <= 8'h00;
            cap_d2    <= 8'h00;
            cap_d3    <= 8'h00;
            x_start   <= 1'b0;
            x_rs      <= 1'b0;
            x_long    <= 1'b0;
            x_byte    <= 8'h00;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            x_start <= 1'b0;
            if (upd_req && state != IDLE)
                pending <= 1'b1;

            case (state)
                PWR_WAIT: begin
                    if (pwr_cnt == PWR_LAST) begin
                        pwr_cnt <= '0;
                        idx     <= 2'd0;
                        state   <= INIT;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                INIT: begin
                    if (!issued && x_ready) begin
                        x_start <= 1'b1;
                        issued  <= 1'b1;
                        x_rs    <= 1'b0;
                        x_byte  <= init_byte;
                        x_long  <= (init_byte == CLEAR);
                    end else if (x_done) begin
                        issued <= 1'b0;
                        if (idx == 2'd3) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                IDLE: begin
                    if (upd_req || pending) begin
                        cap_d1  <= digit1;
                        cap_d2  <= digit2;
                        cap_d3  <= digit3;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (!issued && x_ready) begin
                        x_start <= 1'b1;
                        issued  <= 1'b1;
                        x_rs    <= 1'b0;
                        x_byte  <= LINE1;
                        x_long  <= 1'b0;
                    end else if (x_done) begin
                        issued <= 1'b0;
                        idx    <= 2'd0;
                        state  <= WR_CHAR;
                    end
                end
                WR_CHAR: begin
                    if (!issued && x_ready) begin
                        x_start <= 1'b1;
                        issued  <= 1'b1;
                        x_rs    <= 1'b1;
                        x_byte  <= char_sel;
                        x_long  <= 1'b0;
                    end else if (x_done) begin
                        issued <= 1'b0;
                        if (idx == 2'd2) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

    lcd_byte_xfer #(
        .EN_HIGH_CYC  (EN_HIGH_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) u_xfer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (x_start),
        .rs        (x_rs),
        .data_byte (x_byte),
        .long_wait (x_long),
        .lcd_rs    (lcd_rs),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data),
        .done      (x_done),
        .ready     (x_ready)
    );

endmodule
